// File: rtl/xpu_difftest_pkg.sv
// Shared difftest definitions: beat count, beat index type, streamer states
// and the width of the commit sequence counter.
package xpu_difftest_pkg;

    localparam int DT_NBEATS = 32;
    localparam int DT_SEQ_W  = 32;

    typedef logic [4:0] dt_idx_t;

    localparam dt_idx_t DT_LAST_IDX = dt_idx_t'(DT_NBEATS - 1);

    typedef enum logic {
        DT_IDLE = 1'b0,
        DT_SEND = 1'b1
    } dt_state_e;

endpackage

// File: rtl/difftest_reg_streamer.sv
// Difftest commit streamer: snapshots PC plus x1..x31 (with writeback bypass)
// on each commit and streams it to the checker as a 32-beat packet.
module difftest_reg_streamer
    import xpu_difftest_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_valid_i,
    output logic                   commit_ready_o,
    input  logic [XLEN-1:0]        commit_pc_i,
    input  logic                   commit_we_i,
    input  logic [4:0]             commit_waddr_i,
    input  logic [XLEN-1:0]        commit_wdata_i,
    input  logic [NREG*XLEN-1:0]   diff_reg_i,
    output logic                   dt_valid_o,
    input  logic                   dt_ready_i,
    output logic [4:0]             dt_idx_o,
    output logic [XLEN-1:0]        dt_data_o,
    output logic                   dt_last_o,
    output logic [DT_SEQ_W-1:0]    dt_seq_o
);

    dt_state_e           state;
    dt_idx_t             idx;
    logic [DT_SEQ_W-1:0] seq;
    logic [XLEN-1:0]     snap [DT_NBEATS];
    logic                commit_fire;
    logic                unused_x0;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A producer holds its payload stable while valid && !ready; commit_ready_o
    // and dt_valid_o are decoded from the state register only.
    assign commit_ready_o = (state == DT_IDLE);
    assign dt_valid_o     = (state == DT_SEND);
    assign commit_fire    = commit_valid_i && commit_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DT_IDLE;
            idx   <= '0;
            seq   <= '0;
        end else begin
            case (state)
                DT_IDLE: begin
                    if (commit_valid_i) begin
                        idx   <= '0;
                        seq   <= seq + DT_SEQ_W'(1);
                        state <= DT_SEND;
                    end
                end
                DT_SEND: begin
                    if (dt_ready_i) begin
                        if (idx == DT_LAST_IDX) begin
                            idx   <= '0;
                            state <= DT_IDLE;
                        end else begin
                            idx <= idx + dt_idx_t'(1);
                        end
                    end
                end
                default: state <= DT_IDLE;
            endcase
        end
    end

    // The register file writes at the same edge, so its snapshot is still the
    // pre-write value here; the committing write is bypassed in.
    always_ff @(posedge clk) begin
        if (!rst && commit_fire) begin
            snap[0] <= commit_pc_i;
            for (int k = 1; k < DT_NBEATS; k++) begin
                snap[k] <= (commit_we_i && commit_waddr_i == dt_idx_t'(k))
                           ? commit_wdata_i
                           : diff_reg_i[k*XLEN +: XLEN];
            end
        end
    end

    assign dt_idx_o  = dt_valid_o ? idx : '0;
    assign dt_data_o = dt_valid_o ? snap[idx] : '0;
    assign dt_last_o = dt_valid_o && (idx == DT_LAST_IDX);
    assign dt_seq_o  = seq;

    // x0 is architecturally zero and never transmitted.
    assign unused_x0 = ^diff_reg_i[XLEN-1:0];

endmodule

// File: tb/tb_difftest_reg_streamer.sv
// Randomized bench for difftest_reg_streamer: a queue-of-beats reference model
// predicts every output each cycle, plus directed reset/bypass/x0/wrap cases.
module tb_difftest_reg_streamer;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              commit_valid;
    logic              commit_ready;
    logic [XLEN-1:0]   commit_pc;
    logic              commit_we;
    logic [4:0]        commit_waddr;
    logic [XLEN-1:0]   commit_wdata;
    logic [NREG*XLEN-1:0] diff_reg;
    logic              dt_valid;
    logic              dt_ready;
    logic [4:0]        dt_idx;
    logic [XLEN-1:0]   dt_data;
    logic              dt_last;
    logic [31:0]       dt_seq;

    difftest_reg_streamer #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid_i (commit_valid),
        .commit_ready_o (commit_ready),
        .commit_pc_i    (commit_pc),
        .commit_we_i    (commit_we),
        .commit_waddr_i (commit_waddr),
        .commit_wdata_i (commit_wdata),
        .diff_reg_i     (diff_reg),
        .dt_valid_o     (dt_valid),
        .dt_ready_i     (dt_ready),
        .dt_idx_o       (dt_idx),
        .dt_data_o      (dt_data),
        .dt_last_o      (dt_last),
        .dt_seq_o       (dt_seq)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model: architectural registers and the beats still owed.
    logic [XLEN-1:0]   regs [NREG];
    logic [4+XLEN:0]   exp_q [$];
    logic [31:0]       model_seq;
    int                model_accepts;
    logic              seen_1234;
    int                err_cnt = 0;
    int                chk_cnt = 0;

    always_comb begin
        diff_reg = '0;
        for (int k = 0; k < NREG; k++) diff_reg[k*XLEN +: XLEN] = regs[k];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [4:0]      e_idx;
        logic [XLEN-1:0] e_data;
        if (dt_valid === 1'b1 && dt_data === 64'h1234) seen_1234 = 1'b1;
        check_eq("dt_seq", 64'(dt_seq), 64'(model_seq));
        if (exp_q.size() == 0) begin
            check_eq("idle_valid", 64'(dt_valid), 64'd0);
            check_eq("idle_ready", 64'(commit_ready), 64'd1);
            check_eq("idle_idx", 64'(dt_idx), 64'd0);
            check_eq("idle_data", dt_data, 64'd0);
            check_eq("idle_last", 64'(dt_last), 64'd0);
        end else begin
            {e_idx, e_data} = exp_q[0];
            check_eq("send_valid", 64'(dt_valid), 64'd1);
            check_eq("send_ready", 64'(commit_ready), 64'd0);
            check_eq("beat_idx", 64'(dt_idx), 64'(e_idx));
            check_eq("beat_data", dt_data, e_data);
            check_eq("beat_last", 64'(dt_last), 64'(e_idx == 5'd31));
        end
    endtask

    // Driver: advance the model over the coming edge, clock, then compare.
    task automatic tick();
        logic            do_write = 1'b0;
        logic [4:0]      w_addr = '0;
        logic [XLEN-1:0] w_data = '0;
        logic [XLEN-1:0] d;
        if (rst) begin
            exp_q.delete();
            model_seq = '0;
        end else if (exp_q.size() != 0) begin
            if (dt_ready) void'(exp_q.pop_front());
        end else if (commit_valid) begin
            model_seq++;
            model_accepts++;
            exp_q.push_back({5'd0, commit_pc});
            for (int k = 1; k < NREG; k++) begin
                d = (commit_we && commit_waddr == 5'(k)) ? commit_wdata : regs[k];
                exp_q.push_back({5'(k), d});
            end
            if (commit_we && commit_waddr != 5'd0) begin
                do_write = 1'b1;
                w_addr   = commit_waddr;
                w_data   = commit_wdata;
            end
        end
        @(posedge clk);
        #1;
        if (do_write) regs[w_addr] = w_data;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic randomize_regs();
        regs[0] = '0;
        for (int k = 1; k < NREG; k++) regs[k] = {$urandom, $urandom};
    endtask

    task automatic commit_and_drain(input logic [XLEN-1:0] pc, input logic we,
                                    input logic [4:0] wa, input logic [XLEN-1:0] wd,
                                    input int ready_pct);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_we    = we;
        commit_waddr = wa;
        commit_wdata = wd;
        dt_ready     = ($urandom_range(0, 99) < ready_pct);
        tick();
        commit_valid = 1'b0;
        commit_we    = 1'b0;
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
            dt_ready = ($urandom_range(0, 99) < ready_pct);
            tick();
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
        dt_ready = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_we = 1'b0;
        commit_waddr = '0; commit_wdata = '0; dt_ready = 1'b0;
        model_seq = '0; model_accepts = 0; seen_1234 = 1'b0;
        for (int k = 0; k < NREG; k++) regs[k] = 64'(k);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Identity registers, no write, checker always ready.
        commit_and_drain(64'h8000_0000, 1'b0, 5'd0, 64'd0, 100);

        // Bypass of the committing write into x5.
        regs[5] = 64'h5;
        commit_and_drain({$urandom, $urandom}, 1'b1, 5'd5, 64'hDEAD, 100);

        // A write to x0 must never appear on the stream.
        randomize_regs();
        seen_1234 = 1'b0;
        commit_and_drain({$urandom, $urandom}, 1'b1, 5'd0, 64'h1234, 100);
        check_eq("x0_write_absent", 64'(seen_1234), 64'd0);

        // Back-pressure at 30% with a commit held through the whole packet.
        rst = 1'b1; tick(); rst = 1'b0;
        randomize_regs();
        model_accepts = 0;
        commit_pc = {$urandom, $urandom};
        commit_we = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (model_accepts >= 2 && exp_q.size() == 0) break;
            commit_valid = (model_accepts < 2);
            dt_ready     = ($urandom_range(0, 99) < 30);
            tick();
        end
        commit_valid = 1'b0;
        check_eq("held_commit_done", 64'(model_accepts >= 2 && exp_q.size() == 0), 64'd1);

        // Reset while beat 10 is on the bus truncates the packet.
        randomize_regs();
        commit_valid = 1'b1; commit_pc = {$urandom, $urandom}; dt_ready = 1'b1;
        tick();
        commit_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() != 0 && exp_q[0][XLEN+4:XLEN] == 5'd10) break;
            tick();
        end
        check_eq("reached_idx10", 64'(dt_idx), 64'd10);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst_valid", 64'(dt_valid), 64'd0);
        check_eq("rst_ready", 64'(commit_ready), 64'd1);
        check_eq("rst_seq", 64'(dt_seq), 64'd0);
        commit_and_drain({$urandom, $urandom}, 1'b0, 5'd0, 64'd0, 100);

        // Sequence counter wrap.
        force dut.seq = 32'hFFFF_FFFF;
        #1;
        release dut.seq;
        model_seq = 32'hFFFF_FFFF;
        commit_and_drain({$urandom, $urandom}, 1'b0, 5'd0, 64'd0, 100);

        // Random commits with random writes and back-pressure.
        for (int p = 0; p < 4; p++) begin
            randomize_regs();
            commit_and_drain({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                             5'($urandom_range(0, 31)), {$urandom, $urandom}, 50);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
